// File: rtl/matvec_pkg.sv
// Shared defaults and lane typedefs for the AXIS matrix-vector datapath
// (axis_matvec_mul and axis_requant).
package matvec_pkg;
  localparam int DEF_R     = 8;
  localparam int DEF_C     = 8;
  localparam int DEF_W_X   = 8;
  localparam int DEF_W_K   = 8;
  localparam int DEF_W_Q   = 8;
  localparam int DEF_SHIFT = 8;

  function automatic int w_y(input int w_x, input int w_k, input int c);
    return w_x + w_k + $clog2(c);
  endfunction

  localparam int DEF_W_Y = w_y(DEF_W_X, DEF_W_K, DEF_C);

  typedef logic signed [DEF_W_Y-1:0] y_lane_t;
  typedef logic signed [DEF_W_Q-1:0] q_lane_t;
  typedef y_lane_t [DEF_R-1:0]       y_vec_t;
  typedef q_lane_t [DEF_R-1:0]       q_vec_t;
endpackage

// File: rtl/axis_pipe_reg.sv
// One elastic valid/ready stage: accepts a new word whenever it is empty or
// its current word is leaving in the same cycle.
module axis_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/axis_requant.sv
// Requantizes R signed accumulator lanes: round-half-up shift, then saturate.
// Define RELU_EN to clamp negative results to zero before saturation.
module axis_requant
  import matvec_pkg::*;
#(
  parameter int R     = DEF_R,
  parameter int C     = DEF_C,
  parameter int W_X   = DEF_W_X,
  parameter int W_K   = DEF_W_K,
  parameter int W_Y   = w_y(W_X, W_K, C),
  parameter int W_Q   = DEF_W_Q,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [R*W_Y-1:0]   s_axis_y_tdata,
  input  logic               s_axis_y_tvalid,
  output logic               s_axis_y_tready,
  output logic [R*W_Q-1:0]   m_axis_q_tdata,
  output logic               m_axis_q_tvalid,
  input  logic               m_axis_q_tready
);
  localparam int WS     = W_Y + 1;
  localparam int QMAX_I = (1 << (W_Q - 1)) - 1;
  localparam logic signed [WS-1:0] BIAS = WS'((longint'(1) << SHIFT) >> 1);
  localparam logic signed [WS-1:0] QMAX = WS'(QMAX_I);
  localparam logic signed [WS-1:0] QMIN = WS'(-QMAX_I - 1);

  logic [R*WS-1:0]  s1_d;
  logic [R*WS-1:0]  s1_q;
  logic             s1_valid;
  logic             s2_ready;
  logic [R*W_Q-1:0] s2_d;

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_lane
      logic signed [W_Y-1:0] y_l;
      logic signed [WS-1:0]  t_l;
      logic signed [WS-1:0]  s_l;
      logic signed [WS-1:0]  c_l;

      // One extra bit of headroom so the rounding bias cannot wrap.
      assign y_l = s_axis_y_tdata[gi*W_Y +: W_Y];
      assign t_l = {y_l[W_Y-1], y_l} + BIAS;
      assign s1_d[gi*WS +: WS] = t_l >>> SHIFT;

      assign s_l = s1_q[gi*WS +: WS];
`ifdef RELU_EN
      assign c_l = s_l[WS-1] ? '0 : s_l;
`else
      assign c_l = s_l;
`endif
      assign s2_d[gi*W_Q +: W_Q] = (c_l > QMAX) ? QMAX[W_Q-1:0] :
                                   (c_l < QMIN) ? QMIN[W_Q-1:0] :
                                                  c_l[W_Q-1:0];
    end
  endgenerate

  axis_pipe_reg #(.W(R*WS)) u_stage1 (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (s_axis_y_tvalid),
    .in_ready_o  (s_axis_y_tready),
    .in_data_i   (s1_d),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_q)
  );

  axis_pipe_reg #(.W(R*W_Q)) u_stage2 (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   (s2_d),
    .out_valid_o (m_axis_q_tvalid),
    .out_ready_i (m_axis_q_tready),
    .out_data_o  (m_axis_q_tdata)
  );
endmodule

// File: tb/tb_axis_requant.sv
// Self-checking bench for axis_requant: directed rounding/saturation beats,
// backpressure, throughput, random handshakes and mid-stream reset.
module tb_axis_requant;
  localparam int R     = 8;
  localparam int C     = 8;
  localparam int W_X   = 8;
  localparam int W_K   = 8;
  localparam int W_Y   = 19;
  localparam int W_Q   = 8;
  localparam int SHIFT = 8;

  typedef logic [R*W_Y-1:0] yv_t;
  typedef logic [R*W_Q-1:0] qv_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  yv_t  s_tdata = '0;
  logic s_tvalid = 1'b0;
  logic s_tready;
  qv_t  m_tdata;
  logic m_tvalid;
  logic m_tready = 1'b0;

  int   n_vec = 0;
  int   n_fail = 0;
  int   in_cnt = 0;
  int   out_cnt = 0;
  qv_t  exp_q[$];
  logic hold_v = 1'b0;
  qv_t  hold_d = '0;

  always #5 clk = ~clk;

  axis_requant #(
    .R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_Y(W_Y), .W_Q(W_Q), .SHIFT(SHIFT)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .s_axis_y_tdata  (s_tdata),
    .s_axis_y_tvalid (s_tvalid),
    .s_axis_y_tready (s_tready),
    .m_axis_q_tdata  (m_tdata),
    .m_axis_q_tvalid (m_tvalid),
    .m_axis_q_tready (m_tready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Requantize one integer exactly as the arithmetic rules state.
  function automatic longint requant(input longint y);
    longint den, v, q;
    den = longint'(1) << SHIFT;
    v   = y + den / 2;
    q   = (v >= 0) ? v / den : -((-v + den - 1) / den);
`ifdef RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > (longint'(1) << (W_Q - 1)) - 1) q = (longint'(1) << (W_Q - 1)) - 1;
    if (q < -(longint'(1) << (W_Q - 1)))    q = -(longint'(1) << (W_Q - 1));
    return q;
  endfunction

  function automatic qv_t model(input yv_t d);
    qv_t                   r;
    logic signed [W_Y-1:0] ys;
    longint                q;
    r = '0;
    for (int i = 0; i < R; i++) begin
      ys = d[i*W_Y +: W_Y];
      q  = requant(longint'(ys));
      r[i*W_Q +: W_Q] = q[W_Q-1:0];
    end
    return r;
  endfunction

  function automatic yv_t pack_y(input int a[R]);
    yv_t v;
    for (int i = 0; i < R; i++) v[i*W_Y +: W_Y] = W_Y'(a[i]);
    return v;
  endfunction

  function automatic qv_t pack_q(input int a[R]);
    qv_t v;
    int  t;
    for (int i = 0; i < R; i++) begin
      t = a[i];
`ifdef RELU_EN
      if (t < 0) t = 0;
`endif
      v[i*W_Q +: W_Q] = W_Q'(t);
    end
    return v;
  endfunction

  function automatic yv_t rand_vec();
    yv_t v;
    for (int i = 0; i < R; i++) begin
      if ($urandom_range(1, 0) == 1) v[i*W_Y +: W_Y] = W_Y'($urandom);
      else v[i*W_Y +: W_Y] = W_Y'(int'($urandom_range(8191, 0)) - 4096);
    end
    return v;
  endfunction

  // Drive one cycle from a negedge, observe handshakes just before the
  // rising edge, and return at the following negedge.
  task automatic cycle(input logic iv, input yv_t id, input logic ordy, output logic acc);
    logic emit;
    s_tvalid = iv;
    s_tdata  = id;
    m_tready = ordy;
    #1;
    acc  = iv && s_tready;
    emit = m_tvalid && ordy;
    if (hold_v) begin
      chk("hold_valid", 64'(m_tvalid), 64'd1);
      chk("hold_data", m_tdata, hold_d);
    end
    if (emit) begin
      chk("emit_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("beat_data", m_tdata, exp_q.pop_front());
      out_cnt++;
    end
    if (acc) begin
      exp_q.push_back(model(id));
      in_cnt++;
    end
    hold_v = m_tvalid && !ordy;
    hold_d = m_tdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, a);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic acc;
    int   acc_n, o0, i0, n, cyc;
    logic have;
    yv_t  d;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd1);
    chk("rst_tdata", m_tdata, 64'd0);
    rstn = 1'b1;

    // Rounding and latency
    d = pack_y('{1000, -1000, 384, -384, 0, 255, 32512, -129});
    cycle(1'b1, d, 1'b1, acc);
    chk("round_accept", 64'(acc), 64'd1);
    chk("round_lat1_valid", 64'(m_tvalid), 64'd0);
    cycle(1'b0, '0, 1'b0, acc);
    chk("round_lat2_valid", 64'(m_tvalid), 64'd1);
    chk("round_data", m_tdata, pack_q('{4, -4, 2, -1, 0, 1, 127, -1}));
    drain();

    // Saturation (and the RELU clamp when that build is selected)
    d = pack_y('{40000, -40000, 32640, -32768, 262143, -262144, 1000, 0});
    cycle(1'b1, d, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, acc);
    chk("sat_data", m_tdata, pack_q('{127, -128, 127, -128, 127, -128, 4, 0}));
    drain();

    // Backpressure: only two beats fit
    acc_n = 0;
    o0 = out_cnt;
    d = rand_vec();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, d, 1'b0, acc);
      if (acc) begin
        acc_n++;
        d = rand_vec();
      end
    end
    chk("bp_accepted", 64'(acc_n), 64'd2);
    chk("bp_tready", 64'(s_tready), 64'd0);
    cycle(1'b1, d, 1'b1, acc);
    chk("bp_release_accept", 64'(acc), 64'd1);
    drain();
    chk("bp_out_count", 64'(out_cnt - o0), 64'd3);

    // Full throughput
    o0 = out_cnt;
    for (int i = 0; i < 100; i++) cycle(1'b1, rand_vec(), 1'b1, acc);
    n = 0;
    while (out_cnt - o0 < 100 && n < 10) begin
      cycle(1'b0, '0, 1'b1, acc);
      n++;
    end
    chk("tput_outputs", 64'(out_cnt - o0), 64'd100);
    chk("tput_cycles", 64'(100 + n), 64'd102);

    // Random valid/ready toggling
    i0 = in_cnt;
    have = 1'b0;
    cyc = 0;
    while (in_cnt - i0 < 500 && cyc < 6000) begin
      if (!have && $urandom_range(9, 0) != 0) begin
        d = rand_vec();
        have = 1'b1;
      end
      cycle(have, d, $urandom_range(9, 0) != 0, acc);
      if (acc) have = 1'b0;
      cyc++;
    end
    chk("rand_beats", 64'(in_cnt - i0), 64'd500);
    drain();

    // Reset while two beats are held
    cycle(1'b1, rand_vec(), 1'b0, acc);
    cycle(1'b1, rand_vec(), 1'b0, acc);
    chk("pre_rst_full", 64'(s_tready), 64'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_tready", 64'(s_tready), 64'd1);
    chk("mid_rst_tdata", m_tdata, 64'd0);
    exp_q.delete();
    hold_v = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    d = pack_y('{512, 512, 512, 512, 512, 512, 512, 512});
    cycle(1'b1, d, 1'b1, acc);
    chk("post_rst_accept", 64'(acc), 64'd1);
    cycle(1'b0, '0, 1'b1, acc);
    chk("post_rst_valid", 64'(m_tvalid), 64'd1);
    chk("post_rst_data", m_tdata, pack_q('{2, 2, 2, 2, 2, 2, 2, 2}));
    drain();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
